// File: rtl/cpuid_csr_window_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpuid_csr_window_pkg
//  Brief    : Shared constants and types for the CPUID CSR window:
//             window base address, offset map, STATUS bit positions,
//             privilege levels.
//  Revision : 1.0 - initial release
// ============================================================================
package cpuid_csr_window_pkg;

  // Default CSR address of window offset 0; the window spans 8 addresses
  localparam logic [11:0] CARBON_CSR_CPUID_BASE = 12'hC00;

  // Window offset map
  localparam logic [2:0] CPUID_WIN_LEAF    = 3'd0;
  localparam logic [2:0] CPUID_WIN_SUBLEAF = 3'd1;
  localparam logic [2:0] CPUID_WIN_DATA0   = 3'd2;
  localparam logic [2:0] CPUID_WIN_DATA1   = 3'd3;
  localparam logic [2:0] CPUID_WIN_DATA2   = 3'd4;
  localparam logic [2:0] CPUID_WIN_DATA3   = 3'd5;
  localparam logic [2:0] CPUID_WIN_STATUS  = 3'd6;
  localparam logic [2:0] CPUID_WIN_RSVD    = 3'd7;

  // STATUS register bit positions
  localparam int CPUID_STATUS_SNAP_VALID_BIT = 0;
  localparam int CPUID_STATUS_BUSY_BIT       = 1;

  // Requester privilege levels
  typedef enum logic [1:0] {
    PRIV_U = 2'd0,
    PRIV_S = 2'd1,
    PRIV_H = 2'd2,
    PRIV_M = 2'd3
  } priv_e;

endpackage : cpuid_csr_window_pkg
`default_nettype wire

// File: rtl/cpuid_csr_window_if.sv
`default_nettype none
// ============================================================================
//  Module   : cpuid_csr_window_if
//  Brief    : CSR request/response channel between the core CSR unit
//             (master) and the CPUID window (slave).
//  Revision : 1.0 - initial release
// ============================================================================
interface cpuid_csr_window_if;
  logic        csr_req_valid;
  logic        csr_req_ready;
  logic        csr_req_write;
  logic [11:0] csr_req_addr;
  logic [63:0] csr_req_wdata;
  logic [1:0]  csr_req_priv;
  logic        csr_rsp_valid;
  logic        csr_rsp_ready;
  logic [63:0] csr_rsp_rdata;
  logic        csr_rsp_fault;

  modport master (
    output csr_req_valid, csr_req_write, csr_req_addr, csr_req_wdata,
           csr_req_priv, csr_rsp_ready,
    input  csr_req_ready, csr_rsp_valid, csr_rsp_rdata, csr_rsp_fault
  );

  modport slave (
    input  csr_req_valid, csr_req_write, csr_req_addr, csr_req_wdata,
           csr_req_priv, csr_rsp_ready,
    output csr_req_ready, csr_rsp_valid, csr_rsp_rdata, csr_rsp_fault
  );
endinterface : cpuid_csr_window_if
`default_nettype wire

// File: rtl/cpuid_csr_window.sv
`default_nettype none
// ============================================================================
//  Module   : cpuid_csr_window
//  Brief    : CSR window onto the CPUID leaf model. Selector writes start a
//             fixed-latency lookup whose result is snapshotted into read-only
//             data CSRs; every access is privilege checked and answered with
//             exactly one response.
//  Revision : 1.0 - initial release
// ============================================================================
module cpuid_csr_window
  import cpuid_csr_window_pkg::*;
#(
  parameter logic [11:0] CSR_BASE   = CARBON_CSR_CPUID_BASE,
  parameter int          LOOKUP_LAT = 2,
  parameter logic [1:0]  MIN_PRIV   = PRIV_S
) (
  input  wire logic             clk,
  input  wire logic             rst,
  cpuid_csr_window_if.slave     csr,
  output logic [31:0]           cpuid_leaf,
  output logic [31:0]           cpuid_subleaf,
  input  wire logic [63:0]      cpuid_data0,
  input  wire logic [63:0]      cpuid_data1,
  input  wire logic [63:0]      cpuid_data2,
  input  wire logic [63:0]      cpuid_data3
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // Counter is loaded with LAT-1 so the snapshot lands LAT cycles after the
  // selector changes, giving the combinational CPUID block its settle time.
  localparam logic [3:0] CNT_LOAD = 4'(LOOKUP_LAT - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [31:0]       leaf_q, leaf_d;
  logic [31:0]       subleaf_q, subleaf_d;
  logic [3:0][63:0]  snap_q, snap_d;
  logic              snap_valid_q, snap_valid_d;
  logic [63:0]       rdata_q, rdata_d;
  logic              fault_q, fault_d;

  logic [2:0]        w_off;
  logic              w_priv_ok;
  logic              unused_wdata_hi;

  // Upper write-data half is architecturally ignored by the selector CSRs
  assign unused_wdata_hi = ^csr.csr_req_wdata[63:32];

  assign w_off     = 3'(csr.csr_req_addr - CSR_BASE);
  assign w_priv_ok = (csr.csr_req_priv >= MIN_PRIV);

  assign csr.csr_req_ready = (state_q == ST_IDLE);
  assign csr.csr_rsp_valid = (state_q == ST_RESP);
  assign csr.csr_rsp_rdata = rdata_q;
  assign csr.csr_rsp_fault = fault_q;
  assign cpuid_leaf        = leaf_q;
  assign cpuid_subleaf     = subleaf_q;

  // Next-state, request decode and snapshot capture
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    leaf_d       = leaf_q;
    subleaf_d    = subleaf_q;
    snap_d       = snap_q;
    snap_valid_d = snap_valid_q;
    rdata_d      = rdata_q;
    fault_d      = fault_q;

    case (state_q)
      ST_IDLE: begin
        if (csr.csr_req_valid) begin
          rdata_d = 64'd0;
          fault_d = 1'b0;
          state_d = ST_RESP;
          if (!w_priv_ok) begin
            fault_d = 1'b1;
          end else if (csr.csr_req_write) begin
            if (w_off == CPUID_WIN_LEAF || w_off == CPUID_WIN_SUBLEAF) begin
              if (w_off == CPUID_WIN_LEAF) leaf_d    = csr.csr_req_wdata[31:0];
              else                         subleaf_d = csr.csr_req_wdata[31:0];
              snap_valid_d = 1'b0;
              cnt_d        = CNT_LOAD;
              state_d      = ST_LOOKUP;
            end else begin
              fault_d = 1'b1;
            end
          end else begin
            case (w_off)
              CPUID_WIN_LEAF:    rdata_d = {32'd0, leaf_q};
              CPUID_WIN_SUBLEAF: rdata_d = {32'd0, subleaf_q};
              CPUID_WIN_DATA0:   rdata_d = snap_q[0];
              CPUID_WIN_DATA1:   rdata_d = snap_q[1];
              CPUID_WIN_DATA2:   rdata_d = snap_q[2];
              CPUID_WIN_DATA3:   rdata_d = snap_q[3];
              CPUID_WIN_STATUS: begin
                // busy is always 0 when observable: reads only land in IDLE
                rdata_d[CPUID_STATUS_SNAP_VALID_BIT] = snap_valid_q;
                rdata_d[CPUID_STATUS_BUSY_BIT]       = 1'b0;
              end
              default:           fault_d = 1'b1;
            endcase
          end
        end
      end

      ST_LOOKUP: begin
        if (cnt_q == 4'd0) begin
          snap_d       = {cpuid_data3, cpuid_data2, cpuid_data1, cpuid_data0};
          snap_valid_d = 1'b1;
          rdata_d      = 64'd0;
          fault_d      = 1'b0;
          state_d      = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_RESP: begin
        if (csr.csr_rsp_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and CSR registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      leaf_q       <= 32'd0;
      subleaf_q    <= 32'd0;
      snap_q       <= '0;
      snap_valid_q <= 1'b0;
      rdata_q      <= 64'd0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      leaf_q       <= leaf_d;
      subleaf_q    <= subleaf_d;
      snap_q       <= snap_d;
      snap_valid_q <= snap_valid_d;
      rdata_q      <= rdata_d;
      fault_q      <= fault_d;
    end
  end

endmodule : cpuid_csr_window
`default_nettype wire

// File: tb/tb_cpuid_csr_window.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpuid_csr_window
//  Brief    : Directed self-checking bench for cpuid_csr_window with a small
//             CPUID leaf model and an expected-response queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cpuid_csr_window;
  import cpuid_csr_window_pkg::*;

  localparam logic [11:0] BASE = 12'hC00;
  localparam int          LAT  = 2;

  typedef struct packed {
    logic [63:0] rdata;
    logic        fault;
    logic [7:0]  lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] leaf, subleaf;
  logic [63:0] d0, d1, d2, d3;

  int   vectors     = 0;
  int   miscompares = 0;
  exp_t exp_q[$];

  cpuid_csr_window_if bus ();

  cpuid_csr_window #(
    .CSR_BASE  (BASE),
    .LOOKUP_LAT(LAT),
    .MIN_PRIV  (2'd1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .csr          (bus.slave),
    .cpuid_leaf   (leaf),
    .cpuid_subleaf(subleaf),
    .cpuid_data0  (d0),
    .cpuid_data1  (d1),
    .cpuid_data2  (d2),
    .cpuid_data3  (d3)
  );

  always #5 clk = ~clk;

  // Reference CPUID leaf model: leaf 0 is the vendor leaf, leaf 1 echoes the
  // subleaf, anything else reads as zero.
  always_comb begin
    d0 = 64'd0; d1 = 64'd0; d2 = 64'd0; d3 = 64'd0;
    case (leaf)
      32'h0: begin
        d0 = 64'h0000_0000_0000_0007;
        d1 = 64'h0000_0000_4252_4143;
        d2 = 64'h0000_0000_3038_345A;
        d3 = 64'h0000_0000_4E4F_4252;
      end
      32'h1: begin
        d0 = {subleaf, 32'h0001_0F00};
        d1 = {32'd0, ~subleaf};
      end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full CSR transaction: push expectation, drive, wait (bounded) for
  // the response, compare, optionally stall rsp_ready, then handshake.
  task automatic access(input bit wr, input logic [2:0] off, input logic [63:0] wdata,
                        input logic [1:0] priv, input logic [63:0] exp_rdata,
                        input bit exp_fault, input int exp_lat, input int hold,
                        input string tag);
    exp_t e;
    int   lat;
    bit   seen;
    e.rdata = exp_rdata;
    e.fault = exp_fault;
    e.lat   = 8'(exp_lat);
    exp_q.push_back(e);

    @(negedge clk);
    bus.csr_req_valid = 1'b1;
    bus.csr_req_write = wr;
    bus.csr_req_addr  = BASE + {9'd0, off};
    bus.csr_req_wdata = wdata;
    bus.csr_req_priv  = priv;
    chk({tag, ".req_ready"}, {63'd0, bus.csr_req_ready}, 64'd1);
    chk({tag, ".no_rsp_at_accept"}, {63'd0, bus.csr_rsp_valid}, 64'd0);
    @(posedge clk);
    #1;
    bus.csr_req_valid = 1'b0;
    bus.csr_req_write = 1'b0;

    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (bus.csr_rsp_valid) seen = 1'b1;
    end
    chk({tag, ".rsp_seen"}, {63'd0, seen}, 64'd1);

    e = exp_q.pop_front();
    chk({tag, ".latency"}, 64'(lat), 64'(e.lat));
    chk({tag, ".rdata"}, bus.csr_rsp_rdata, e.rdata);
    chk({tag, ".fault"}, {63'd0, bus.csr_rsp_fault}, {63'd0, e.fault});
    chk({tag, ".ready_busy"}, {63'd0, bus.csr_req_ready}, 64'd0);

    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, ".hold_rdata"}, bus.csr_rsp_rdata, e.rdata);
      chk({tag, ".hold_valid"}, {63'd0, bus.csr_rsp_valid}, 64'd1);
      chk({tag, ".hold_ready"}, {63'd0, bus.csr_req_ready}, 64'd0);
    end

    bus.csr_rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.csr_rsp_ready = 1'b0;
    @(negedge clk);
    chk({tag, ".ready_after"}, {63'd0, bus.csr_req_ready}, 64'd1);
    chk({tag, ".rsp_dropped"}, {63'd0, bus.csr_rsp_valid}, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst               = 1'b1;
    bus.csr_req_valid = 1'b0;
    bus.csr_req_write = 1'b0;
    bus.csr_req_addr  = BASE;
    bus.csr_req_wdata = 64'd0;
    bus.csr_req_priv  = 2'd0;
    bus.csr_rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst.req_ready", {63'd0, bus.csr_req_ready}, 64'd1);
    chk("rst.rsp_valid", {63'd0, bus.csr_rsp_valid}, 64'd0);
    chk("rst.rdata", bus.csr_rsp_rdata, 64'd0);
    chk("rst.fault", {63'd0, bus.csr_rsp_fault}, 64'd0);
    chk("rst.leaf", {32'd0, leaf}, 64'd0);
    chk("rst.subleaf", {32'd0, subleaf}, 64'd0);

    // Status after reset, then vendor leaf lookup
    access(0, CPUID_WIN_STATUS, 64'd0, 2'd2, 64'd0, 0, 1, 0, "status_rst");
    access(0, CPUID_WIN_DATA1, 64'd0, 2'd2, 64'd0, 0, 1, 0, "data1_rst");
    access(1, CPUID_WIN_LEAF, 64'd0, 2'd1, 64'd0, 0, LAT + 1, 0, "wr_leaf0");
    access(0, CPUID_WIN_DATA1, 64'd0, 2'd1, 64'h0000_0000_4252_4143, 0, 1, 0, "vendor_d1");
    access(0, CPUID_WIN_DATA0, 64'd0, 2'd1, 64'h7, 0, 1, 0, "vendor_d0");
    access(0, CPUID_WIN_DATA3, 64'd0, 2'd3, 64'h0000_0000_4E4F_4252, 0, 1, 0, "vendor_d3");
    access(0, CPUID_WIN_STATUS, 64'd0, 2'd1, 64'h1, 0, 1, 0, "status_valid");

    // Subleaf write ignores the upper half; leaf 1 uses it
    access(1, CPUID_WIN_SUBLEAF, 64'hDEAD_BEEF_AAAA_5555, 2'd3, 64'd0, 0, LAT + 1, 0, "wr_sub");
    access(0, CPUID_WIN_SUBLEAF, 64'd0, 2'd1, 64'h0000_0000_AAAA_5555, 0, 1, 0, "rd_sub");
    access(1, CPUID_WIN_LEAF, 64'h1, 2'd2, 64'd0, 0, LAT + 1, 0, "wr_leaf1");
    access(0, CPUID_WIN_DATA0, 64'd0, 2'd1, 64'hAAAA_5555_0001_0F00, 0, 1, 0, "leaf1_d0");
    access(0, CPUID_WIN_DATA1, 64'd0, 2'd1, 64'h0000_0000_5555_AAAA, 0, 1, 0, "leaf1_d1");

    // Unknown leaf: all data lanes zero
    access(1, CPUID_WIN_LEAF, 64'hFFFF_FFFF_FFFF_1234, 2'd1, 64'd0, 0, LAT + 1, 0, "wr_unk");
    access(0, CPUID_WIN_DATA0, 64'd0, 2'd1, 64'd0, 0, 1, 0, "unk_d0");
    access(0, CPUID_WIN_DATA1, 64'd0, 2'd1, 64'd0, 0, 1, 0, "unk_d1");
    access(0, CPUID_WIN_DATA2, 64'd0, 2'd1, 64'd0, 0, 1, 0, "unk_d2");
    access(0, CPUID_WIN_DATA3, 64'd0, 2'd1, 64'd0, 0, 1, 0, "unk_d3");
    access(0, CPUID_WIN_LEAF, 64'd0, 2'd1, 64'h0000_0000_FFFF_1234, 0, 1, 0, "rd_unk_leaf");

    // Same leaf value twice still performs a full lookup each time
    access(1, CPUID_WIN_LEAF, 64'd0, 2'd1, 64'd0, 0, LAT + 1, 0, "wr_leaf0_a");
    access(1, CPUID_WIN_LEAF, 64'd0, 2'd1, 64'd0, 0, LAT + 1, 0, "wr_leaf0_b");

    // Privilege faults leave selectors and snapshots alone
    access(1, CPUID_WIN_LEAF, 64'h5, 2'd0, 64'd0, 1, 1, 0, "upriv_wr");
    access(0, CPUID_WIN_DATA1, 64'd0, 2'd0, 64'd0, 1, 1, 0, "upriv_rd");
    chk("upriv.leaf_port", {32'd0, leaf}, 64'd0);
    access(0, CPUID_WIN_LEAF, 64'd0, 2'd1, 64'd0, 0, 1, 0, "leaf_unchanged");
    access(0, CPUID_WIN_STATUS, 64'd0, 2'd1, 64'h1, 0, 1, 0, "snapv_unchanged");

    // Illegal writes and reserved offset
    access(1, CPUID_WIN_DATA2, 64'h1234, 2'd3, 64'd0, 1, 1, 0, "wr_data2");
    access(1, CPUID_WIN_STATUS, 64'h0, 2'd3, 64'd0, 1, 1, 0, "wr_status");
    access(0, CPUID_WIN_RSVD, 64'd0, 2'd3, 64'd0, 1, 1, 0, "rd_rsvd");
    access(1, CPUID_WIN_RSVD, 64'h5, 2'd3, 64'd0, 1, 1, 0, "wr_rsvd");
    access(0, CPUID_WIN_DATA1, 64'd0, 2'd1, 64'h0000_0000_4252_4143, 0, 1, 0, "snap_kept");
    access(0, CPUID_WIN_LEAF, 64'd0, 2'd1, 64'd0, 0, 1, 0, "leaf_kept");

    // Response backpressure
    access(0, CPUID_WIN_DATA2, 64'd0, 2'd1, 64'h0000_0000_3038_345A, 0, 1, 5, "bp_d2");

    // Reset while a lookup is in flight
    @(negedge clk);
    bus.csr_req_valid = 1'b1;
    bus.csr_req_write = 1'b1;
    bus.csr_req_addr  = BASE + {9'd0, CPUID_WIN_LEAF};
    bus.csr_req_wdata = 64'h7;
    bus.csr_req_priv  = 2'd3;
    @(posedge clk);
    #1;
    bus.csr_req_valid = 1'b0;
    bus.csr_req_write = 1'b0;
    @(negedge clk);
    chk("lookup.leaf", {32'd0, leaf}, 64'h7);
    chk("lookup.req_ready", {63'd0, bus.csr_req_ready}, 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst.rsp_valid", {63'd0, bus.csr_rsp_valid}, 64'd0);
    chk("midrst.leaf", {32'd0, leaf}, 64'd0);
    chk("midrst.req_ready", {63'd0, bus.csr_req_ready}, 64'd1);
    access(0, CPUID_WIN_STATUS, 64'd0, 2'd2, 64'd0, 0, 1, 0, "midrst_status");
    access(0, CPUID_WIN_DATA1, 64'd0, 2'd2, 64'd0, 0, 1, 0, "midrst_d1");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_cpuid_csr_window
`default_nettype wire
